// File: rtl/barrel_unshift.sv
// Multi-cycle inverse rotator: captures one rotated word, undoes the rotation one
// power-of-two stage per clock, then holds the restored word until the consumer takes it.
module barrel_unshift #(
  parameter int unsigned BIT = 8,
  localparam int unsigned STG = $clog2(BIT)
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [BIT-1:0] i_data,
  input  logic           sel_left,
  input  logic [STG-1:0] i_shifter,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [BIT-1:0] o_data
);

  localparam int unsigned CNT_W = (STG > 1) ? $clog2(STG) : 1;
  localparam logic [CNT_W-1:0] LAST_STG = CNT_W'(STG - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [BIT-1:0]   r_data;
  logic [STG-1:0]   r_shift;
  logic             r_left;
  logic [CNT_W-1:0] r_cnt;

  logic [BIT-1:0]   w_rr [STG];
  logic [BIT-1:0]   w_rl [STG];
  logic [BIT-1:0]   w_rot;
  logic             w_accept;
  logic             w_last;

  // Fixed-amount rotations for each stage; stage k moves by 2^k.
  for (genvar k = 0; k < STG; k++) begin : g_stage
    localparam int unsigned SH = 1 << k;
    assign w_rr[k] = {r_data[SH-1:0], r_data[BIT-1:SH]};
    assign w_rl[k] = {r_data[BIT-1-SH:0], r_data[BIT-1:BIT-SH]};
  end

  // A word rotated left is restored by rotating right, and vice versa.
  always_comb begin
    w_rot = r_data;
    for (int k = 0; k < STG; k++) begin
      if (r_cnt == CNT_W'(k) && r_shift[k]) begin
        w_rot = r_left ? w_rr[k] : w_rl[k];
      end
    end
  end

  assign w_accept = (r_state == StIdle) && i_valid;
  assign w_last   = (r_cnt == LAST_STG);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_valid) w_state_nxt = StBusy;
      StBusy:  if (w_last) w_state_nxt = StDone;
      StDone:  if (i_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (r_state)
      StIdle:  o_ready = 1'b1;
      StBusy:  o_ready = 1'b0;
      StDone:  o_valid = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data  <= '0;
      r_shift <= '0;
      r_left  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_data  <= i_data;
      r_shift <= i_shifter;
      r_left  <= sel_left;
      r_cnt   <= '0;
    end else if (r_state == StBusy) begin
      r_data <= w_rot;
      r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_data = r_data;

endmodule

// File: tb/tb_barrel_unshift.sv
// Randomized bench for barrel_unshift: words are rotated by a bench-side forward model,
// fed through the DUT and checked against the original data in order.
module tb_barrel_unshift;

  localparam int unsigned BIT = 8;
  localparam int unsigned STG = 3;

  logic           clk;
  logic           i_rstn;
  logic           i_valid;
  logic           o_ready;
  logic [BIT-1:0] i_data;
  logic           sel_left;
  logic [STG-1:0] i_shifter;
  logic           o_valid;
  logic           i_ready;
  logic [BIT-1:0] o_data;

  int        n_chk = 0;
  int        n_fail = 0;
  int        cyc = 0;
  int        mode = 0;
  logic [7:0] drv_exp = '0;

  logic [7:0] q[$];
  bit         inflight = 1'b0;
  int         acc_edge = 0;
  logic [7:0] last_out = '0;
  int         n_acc = 0;
  int         n_del = 0;

  barrel_unshift #(.BIT(BIT)) dut (
    .i_clk     (clk),
    .i_rstn    (i_rstn),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .sel_left  (sel_left),
    .i_shifter (i_shifter),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int a);
    int v;
    v = int'(x);
    v = (v << a) | (v >> (8 - a));
    return v[7:0];
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] x, input int a);
    return rotl(x, (8 - a) % 8);
  endfunction

  function automatic logic [7:0] fwd(input logic [7:0] x, input bit left, input int a);
    return left ? rotl(x, a) : rotr(x, a);
  endfunction

  function automatic logic [7:0] undo(input logic [7:0] x, input bit left, input int a);
    return left ? rotr(x, a) : rotl(x, a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [7:0] din, input bit left, input int amt,
                      input logic [7:0] exp, input bit keep);
    bit acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    i_data    = din;
    sel_left  = left;
    i_shifter = amt[STG-1:0];
    drv_exp   = exp;
    i_valid   = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (o_ready) acc = 1'b1;
    end
    if (!acc) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    if (!keep) i_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = 1'($urandom_range(0, 1));
        default: i_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: one accepted word in flight, its result due STG edges after acceptance.
  initial forever begin
    bit exp_valid;
    bit was_inflight;
    @(negedge clk);
    if (i_rstn) begin
      was_inflight = inflight;
      exp_valid = inflight && (cyc >= acc_edge + int'(STG));
      chk("o_valid", 32'(o_valid), 32'(exp_valid));
      chk("o_ready", 32'(o_ready), 32'(!was_inflight));
      if (exp_valid && q.size() > 0) begin
        chk("o_data", 32'(o_data), 32'(q[0]));
        if (i_ready) begin
          last_out = q.pop_front();
          inflight = 1'b0;
          n_del++;
        end
      end else if (!was_inflight) begin
        chk("o_data_hold", 32'(o_data), 32'(last_out));
      end
      if (!was_inflight && i_valid) begin
        q.push_back(drv_exp);
        inflight = 1'b1;
        acc_edge = cyc + 1;
        n_acc++;
      end
    end
  end

  initial begin
    bit done;
    i_rstn = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    sel_left = 1'b0;
    i_shifter = '0;

    chk("model_pin_left", 32'(undo(8'b1100_1100, 1'b1, 1)), 32'h66);
    chk("model_pin_right", 32'(undo(8'b1000_0001, 1'b0, 3)), 32'h0C);
    chk("model_pin_fwd", 32'(fwd(8'hA5, 1'b1, 4)), 32'h5A);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    i_rstn = 1'b1;

    // Abort a word with reset one cycle into BUSY.
    send(8'hA5, 1'b0, 3, undo(8'hA5, 1'b0, 3), 1'b0);
    @(posedge clk);
    #1;
    i_rstn = 1'b0;
    q.delete();
    inflight = 1'b0;
    last_out = '0;
    n_acc = 0;
    n_del = 0;
    #1;
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_data", 32'(o_data), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    i_rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_ghost", 32'(o_valid), 32'd0);

    send(8'b1100_1100, 1'b1, 1, undo(8'b1100_1100, 1'b1, 1), 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_left_valid", 32'(o_valid), 32'd1);
    chk("lit_left_data", 32'(o_data), 32'b0110_0110);
    @(negedge clk);
    chk("lit_left_one_cycle", 32'(o_valid), 32'd0);

    send(8'b1000_0001, 1'b0, 3, undo(8'b1000_0001, 1'b0, 3), 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_right_valid", 32'(o_valid), 32'd1);
    chk("lit_right_data", 32'(o_data), 32'b0000_1100);

    send(8'h5A, 1'b1, 0, 8'h5A, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("zero_amt_early", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("zero_amt_valid", 32'(o_valid), 32'd1);
    chk("zero_amt_data", 32'(o_data), 32'h5A);

    // Back-pressure: hold DONE while inputs churn.
    mode = 2;
    send(8'h96, 1'b1, 2, undo(8'h96, 1'b1, 2), 1'b0);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_ready", 32'(o_ready), 32'd0);
      chk("stall_data", 32'(o_data), 32'hA5);
      @(posedge clk);
      #1;
      i_data = 8'($urandom);
      sel_left = ~sel_left;
      i_valid = ~i_valid;
    end
    i_valid = 1'b0;
    mode = 0;
    done = 1'b0;
    for (int t = 0; t < 5 && !done; t++) begin
      @(negedge clk);
      if (!o_valid) done = 1'b1;
    end
    chk("stall_release", 32'(done), 32'd1);
    chk("stall_idle_ready", 32'(o_ready), 32'd1);
    chk("stall_idle_data", 32'(o_data), 32'hA5);

    // Forward-rotate every value, direction and amount; valid held high throughout.
    n_acc = 0;
    n_del = 0;
    mode = 1;
    for (int d = 0; d < 256; d++) begin
      for (int dir = 0; dir < 2; dir++) begin
        for (int a = 0; a < 8; a++) begin
          send(fwd(8'(d), dir[0], a), dir[0], a, 8'(d), 1'b1);
        end
      end
    end
    i_valid = 1'b0;
    mode = 0;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (!inflight) done = 1'b1;
    end
    chk("sweep_drain", 32'(done), 32'd1);
    chk("sweep_queue_empty", 32'(q.size()), 32'd0);
    chk("sweep_accepted", 32'(n_acc), 32'd4096);
    chk("sweep_delivered", 32'(n_del), 32'd4096);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_unshift.md
# barrel_unshift

Multi-cycle inverse rotator that restores a word rotated by the `barrel_shift` datapath, given the same direction and amount. It accepts one word through a valid/ready handshake and undoes the rotation with one log2 stage per clock. It then holds the restored word until the consumer accepts it. The block sits on the receive side of the shift datapath and uses the same data/direction/amount encoding, so the two blocks can be chained back-to-back in benches.

## Interface
- `BIT`, 8: data width; power of two, ≥ 2. `STG = $clog2(BIT)`.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rstn`  in  1: asynchronous, active-low reset.
- `i_valid`  in  1: input word is present.
- `o_ready`  out  1: block can accept a word.
- `i_data`  in  BIT: rotated word to restore.
- `sel_left`  in  1: 1 = word was rotated left (undo by rotating right); 0 = word was rotated right (undo by rotating left).
- `i_shifter`  in  STG: rotation amount applied upstream, 0..BIT-1.
- `o_valid`  out  1: restored word is present on `o_data`.
- `i_ready`  in  1: consumer accepts `o_data`.
- `o_data`  out  BIT: restored word.

## Operation
- Rotation only (circular). No fill bits. Amount is taken modulo BIT by construction of the STG-bit field.
- FSM states:
  - IDLE: `o_ready`=1, `o_valid`=0.
  - BUSY: `o_ready`=0, `o_valid`=0.
  - DONE: `o_ready`=0, `o_valid`=1.
- `o_ready` is decoded from state only (state == IDLE). It never depends combinationally on `i_valid`.
- IDLE → BUSY on an edge with `i_valid && o_ready`:
  - Capture `i_data` into the working register.
  - Capture `sel_left` and `i_shifter`.
  - Clear the stage counter to 0.
- BUSY, stage k (k = counter value):
  - If `shift_q[k]` = 1, rotate the working register by 2^k opposite to the captured `sel_left`. Otherwise hold it.
  - Increment the counter.
- BUSY → DONE on the edge that applies stage STG-1. The counter wraps to 0 and is not used in DONE.
- DONE: the working register drives `o_data` and is held stable.
- DONE → IDLE on an edge with `i_ready`=1. `o_data` keeps its last value; only `o_valid` drops.
- Inputs are ignored in BUSY and DONE. Changes to `i_data`, `sel_left` or `i_shifter` after capture have no effect.
- `i_shifter` = 0 still takes the full STG stages: fixed latency, data unchanged.
- Back-pressure: `i_ready`=0 holds DONE, `o_valid` and `o_data` indefinitely.

## Timing
- Reset values (asynchronous, while `i_rstn`=0):
  - state = IDLE.
  - `o_ready`=1, `o_valid`=0, `o_data`=0.
  - Working register, captured amount, captured direction and counter all 0.
- Reset asserted in BUSY or DONE aborts the operation. The in-flight word is discarded and not presented after reset release.
- Latency: a word accepted at edge N raises `o_valid` after edge N+STG (N+3 for BIT=8).
- The earliest next accept is the edge after the `i_ready` handshake. Peak throughput is one word per STG+2 cycles (5 for BIT=8).
- Handshake with `i_ready` held at 1 while DONE is entered: `o_valid` is high for exactly one cycle.
- `i_valid` held continuously high: words are accepted only in IDLE, one per handshake, with no duplicate capture.

## Test plan
- BIT=8, reset pulse mid-BUSY (`i_data`=8'hA5 accepted, reset after 1 cycle) -> `o_valid`=0, `o_data`=8'h00, `o_ready`=1 immediately. No output appears for 8'hA5.
- `i_data`=8'b1100_1100, `sel_left`=1, `i_shifter`=1, `i_ready`=1 -> `o_data`=8'b0110_0110 with `o_valid` high 3 cycles after accept, for 1 cycle.
- `i_data`=8'b1000_0001, `sel_left`=0, `i_shifter`=3 -> `o_data`=8'b0000_1100. Also `i_shifter`=0 with any data -> data unchanged, still 3-cycle latency.
- Hold `i_ready`=0 for 10 cycles in DONE while toggling `i_data`, `sel_left` and `i_valid` -> `o_data` and `o_valid`=1 stable, `o_ready`=0. On `i_ready`=1, return to IDLE the next cycle.
- Chain `barrel_shift` → `barrel_unshift` and sweep all 256 data values × both directions × amounts 0..7 with random `i_ready` stalls -> every `o_data` equals the original data, in order, with none lost or duplicated.
